// File: rtl/irq_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter_if
//  Brief    : Source, configuration and core-handshake bundle for irq_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface irq_arbiter_if #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
);
  logic [N_SRC-1:0] src_irq;
  logic             cfg_we;
  logic [N_SRC-1:0] cfg_en;
  logic             irq_ack;
  logic             irq_done;
  logic             irq_req;
  logic [ID_W-1:0]  irq_id;
  logic             in_service;
  logic [N_SRC-1:0] pending_o;

  // master: the core / source side that drives the arbiter
  modport master (
    output src_irq, cfg_we, cfg_en, irq_ack, irq_done,
    input  irq_req, irq_id, in_service, pending_o
  );

  modport slave (
    input  src_irq, cfg_we, cfg_en, irq_ack, irq_done,
    output irq_req, irq_id, in_service, pending_o
  );
endinterface
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter
//  Brief    : Edge-latched, masked, round-robin interrupt arbiter presenting a
//             single request/ID to the core with an ack/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  wire logic        clk,
  input  wire logic        reset,
  irq_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q_q, src_q_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;

  logic [N_SRC-1:0] src_edge;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr_mask;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  scan_idx;

  always_comb begin
    src_q_d  = bus.src_irq;
    src_edge = bus.src_irq & ~src_q_q;
    en_d     = bus.cfg_we ? bus.cfg_en : en_q;
    eligible = pending_q & en_q;

    // Scan from the farthest offset down so the last hit is the one nearest rr_ptr;
    // the index wraps naturally because N_SRC == 2**ID_W.
    win_id   = '0;
    scan_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      scan_idx = rr_ptr_q + ID_W'(i);
      if (eligible[scan_idx]) begin
        win_id = scan_idx;
      end
    end

    state_d  = state_q;
    irq_id_d = irq_id_q;
    rr_ptr_d = rr_ptr_q;
    clr_mask = '0;

    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          irq_id_d = win_id;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack) begin
          clr_mask[irq_id_q] = 1'b1;
          rr_ptr_d           = irq_id_q + 1'b1;
          state_d            = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.irq_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A fresh edge on the source being claimed keeps it pending.
    pending_d = (pending_q & ~clr_mask) | src_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      src_q_q   <= '0;
      pending_q <= '0;
      en_q      <= '0;
      rr_ptr_q  <= '0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      src_q_q   <= src_q_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      rr_ptr_q  <= rr_ptr_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign bus.irq_req    = (state_q == ST_REQ);
  assign bus.in_service = (state_q == ST_SERVICE);
  assign bus.irq_id     = irq_id_q;
  assign bus.pending_o  = pending_q;

endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
# irq_arbiter

Multi-source interrupt arbiter in front of the core's single-input interrupt controller. It edge-detects up to N_SRC interrupt sources (NoC router, spike unit, timers), latches them as pending, and applies a per-source enable mask. It picks one eligible source by round-robin and presents it to the core as a single request with an ID, using an ack/done handshake. Only one interrupt is in service at a time; there is no nesting.

## Interface

- N_SRC, 8, number of interrupt sources; must equal 2**ID_W
- ID_W, 3, width of source ID
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- src_irq  in  N_SRC  raw source lines; rising edge = new interrupt
- cfg_we  in  1  enable-mask write strobe
- cfg_en  in  N_SRC  enable mask value written when cfg_we=1
- irq_ack  in  1  core has taken the presented interrupt (entering ISR)
- irq_done  in  1  core has returned from ISR
- irq_req  out  1  interrupt request to core
- irq_id  out  ID_W  ID of requested/in-service source
- in_service  out  1  an ISR is executing
- pending_o  out  N_SRC  pending bits, for CSR readback

## Operation

- Registers: src_q[N_SRC], pending[N_SRC], en[N_SRC], rr_ptr[ID_W], state, irq_id.
- Edge detect: src_q <= src_irq every cycle. A source has an edge when src_irq & ~src_q; that edge sets its pending bit.
- Because src_q resets to 0, a line already high when reset is released is seen as an edge on the first cycle after reset.
- Pending bits latch whether or not the source is enabled.
- Eligible = pending & en.
- cfg_we=1: en <= cfg_en next edge.
- Round-robin winner: the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_SRC.
- FSM states:
  - IDLE: irq_req=0, in_service=0. If any eligible, register irq_id <= winner and go to REQ.
  - REQ: irq_req=1, irq_id held stable.
    - Masking the source or its line changing does not withdraw the request.
    - On irq_ack: clear pending[irq_id], set rr_ptr <= irq_id+1 (mod N_SRC, natural ID_W wrap), go to SERVICE.
  - SERVICE: irq_req=0, in_service=1, irq_id held. On irq_done go to IDLE.
- Ignored inputs: irq_ack outside REQ; irq_done outside SERVICE.
- Set/clear collision: if a new edge on source i coincides with the claim of i, pending[i] ends at 1 (set wins).
- Reset values: irq_req=0, irq_id=0, in_service=0, pending_o=0, en=0, rr_ptr=0, src_q=0, state=IDLE.
- Reset has priority over every other event. Reset in any state, including REQ or SERVICE, discards the request and all pending bits.

## Timing

- Input edge sampled at clock edge k sets pending, visible on pending_o after edge k.
- irq_req rises after edge k+1, with irq_id valid in the same cycle. Latency is 2 cycles from the sampled edge, provided the source is enabled and the FSM is idle.
- irq_ack sampled high at edge m while in REQ: irq_req=0 and in_service=1 after edge m, and pending bit clear after edge m.
- irq_done sampled at edge d: in_service=0 after edge d. IDLE lasts at least one cycle, so the next irq_req rises after edge d+1 at the earliest.
- cfg_en written at edge w affects eligibility from cycle w+1.
- A level held high produces exactly one pending event until it goes low and rises again.

## Test plan

1. Reset, en=0, src_irq=8'hFF → pending_o=8'hFF, irq_req stays 0 for 10 cycles. Then write cfg_en=8'h01 → irq_req=1, irq_id=0, 2 cycles after the write edge.
2. en=8'hFF, one-cycle pulse on src_irq[5] → irq_req=1 and irq_id=5 two edges later. Then ack → pending_o[5]=0, in_service=1. Then done → in_service=0, irq_req=0.
3. Round-robin ordering:
   - Pending {1,3,6}, rr_ptr=0 → grants in order 1, 3, 6.
   - Then raise {1,6} → grant 1 (ptr 7 wraps), then 6.
4. Collision: pulse src_irq[2] in the cycle irq_ack claims id 2 → pending_o[2]=1 after ack. Source 2 is re-requested one cycle after done.
5. Hold src_irq[4] high for 20 cycles across a full ack/done → exactly one grant of id 4. Mask source 4 while in REQ → irq_req stays 1 until ack.
6. Assert reset during SERVICE with pending {0,7} → all outputs 0 next cycle and rr_ptr=0. irq_done right after reset is ignored.
